psum_acc_buf: RTL and testbench

- Multi-lane partial-sum accumulation buffer for the FSRCNN conv datapath.
- Replaces plain write/read psum storage with in-place read-modify-write accumulation: NCH lanes per address, per-lane enable, first-pass initialisation, signed saturation with sticky flags.
- A one-deep forwarding path resolves back-to-back accesses to the same address.
- An independent read port drains finished sums to the output/requant stage.

---
 rtl/psum_acc_buf.sv | 111 +++++++++++
 tb/tb_psum_acc_buf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_buf.sv
// Multi-lane partial-sum accumulation buffer: in-place read-modify-write per lane with
// first-pass initialisation, signed saturation, sticky flags, forwarding and a drain port.
module psum_acc_buf #(
  parameter int DW  = 40,
  parameter int IW  = 32,
  parameter int AW  = 10,
  parameter int NCH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_valid,
  input  logic                acc_first,
  input  logic [AW-1:0]       acc_addr,
  input  logic [NCH-1:0]      acc_lane_en,
  input  logic [NCH*IW-1:0]   acc_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic                rd_valid,
  output logic [NCH*DW-1:0]   rd_data,
  output logic [NCH-1:0]      sat_flag,
  input  logic                sat_clr,
  output logic                busy
);

  localparam int DP = 1 << AW;

  logic [NCH*DW-1:0] r_mem [DP];
  logic [NCH*DW-1:0] r_ram_q;
  logic [NCH*DW-1:0] r_fwd_data;
  logic              r_fwd_sel;

  logic              r_s1_valid;
  logic              r_s1_first;
  logic [AW-1:0]     r_s1_addr;
  logic [NCH-1:0]    r_s1_lane_en;
  logic [NCH*IW-1:0] r_s1_data;

  logic              r_rd_valid;
  logic [NCH*DW-1:0] r_rd_data;
  logic [NCH-1:0]    r_sat;

  logic [NCH*DW-1:0] w_old;
  logic [NCH*DW-1:0] w_result;
  logic [NCH-1:0]    w_sat;
  logic              w_rd_hit;

  // The RAM read of an op issued right after a same-address op misses that op's write.
  assign w_old    = r_fwd_sel ? r_fwd_data : r_ram_q;
  assign w_rd_hit = r_s1_valid && (r_s1_addr == rd_addr);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
      logic [DW-1:0] w_base;
      logic [DW:0]   w_sum;
      logic          w_ovf;

      assign w_base = r_s1_first ? '0 : w_old[gi*DW +: DW];
      assign w_sum  = {w_base[DW-1], w_base}
                    + {{(DW+1-IW){r_s1_data[gi*IW+IW-1]}}, r_s1_data[gi*IW +: IW]};
      assign w_ovf  = w_sum[DW] ^ w_sum[DW-1];

      assign w_result[gi*DW +: DW] =
          !r_s1_lane_en[gi] ? w_old[gi*DW +: DW] :
          !w_ovf            ? w_sum[DW-1:0] :
          w_sum[DW]         ? {1'b1, {(DW-1){1'b0}}} :
                              {1'b0, {(DW-1){1'b1}}};
      assign w_sat[gi] = r_s1_lane_en[gi] & w_ovf;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_fwd_sel  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_sat      <= '0;
    end else begin
      r_s1_valid <= acc_valid;
      r_fwd_sel  <= acc_valid && r_s1_valid && (acc_addr == r_s1_addr);
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_hit ? w_result : r_mem[rd_addr];
      end
      if (sat_clr) begin
        r_sat <= '0;
      end else if (r_s1_valid) begin
        r_sat <= r_sat | w_sat;
      end
    end
  end

  // Datapath and storage carry no reset; a dropped op is suppressed via r_s1_valid.
  always_ff @(posedge clk) begin
    r_s1_first   <= acc_first;
    r_s1_addr    <= acc_addr;
    r_s1_lane_en <= acc_lane_en;
    r_s1_data    <= acc_data;
    r_fwd_data   <= w_result;
    r_ram_q      <= r_mem[acc_addr];
    if (r_s1_valid) begin
      r_mem[r_s1_addr] <= w_result;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign sat_flag = r_sat;
  assign busy     = r_s1_valid;

endmodule

// File: tb/tb_psum_acc_buf.sv
// Directed bench for psum_acc_buf: hand-computed vectors checked with immediate assertions.
module tb_psum_acc_buf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         acc_valid;
  logic         acc_first;
  logic [9:0]   acc_addr;
  logic [3:0]   acc_lane_en;
  logic [127:0] acc_data;
  logic         rd_en;
  logic [9:0]   rd_addr;
  logic         rd_valid;
  logic [159:0] rd_data;
  logic [3:0]   sat_flag;
  logic         sat_clr;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  psum_acc_buf #(.DW(40), .IW(32), .AW(10), .NCH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_valid  (acc_valid),
    .acc_first  (acc_first),
    .acc_addr   (acc_addr),
    .acc_lane_en(acc_lane_en),
    .acc_data   (acc_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .sat_flag   (sat_flag),
    .sat_clr    (sat_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pk(int a0, int a1, int a2, int a3);
    pk = {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] ln(int i);
    ln = {24'b0, rd_data[i*40 +: 40]};
  endfunction

  function automatic logic [63:0] e40(longint v);
    logic [63:0] t;
    t = v;
    e40 = {24'b0, t[39:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic first, logic [9:0] addr, logic [3:0] en, logic [127:0] d);
    acc_valid   = 1'b1;
    acc_first   = first;
    acc_addr    = addr;
    acc_lane_en = en;
    acc_data    = d;
  endtask

  task automatic idle();
    acc_valid = 1'b0;
    rd_en     = 1'b0;
    sat_clr   = 1'b0;
  endtask

  task automatic chk_lanes(string tag, longint v0, longint v1, longint v2, longint v3);
    chk({tag, "_l0"}, ln(0), e40(v0));
    chk({tag, "_l1"}, ln(1), e40(v1));
    chk({tag, "_l2"}, ln(2), e40(v2));
    chk({tag, "_l3"}, ln(3), e40(v3));
  endtask

  localparam longint MAXI = 64'sd2147483647;   // 2^31-1
  localparam longint MAXD = 64'sd549755813887; // 2^39-1

  initial begin
    rst_n = 1'b0;
    idle();
    acc_first = 1'b0; acc_addr = '0; acc_lane_en = '0; acc_data = '0; rd_addr = '0;
    step(); step();
    chk("rst_rd_valid", {63'b0, rd_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_sat", {60'b0, sat_flag}, 64'd0);
    chk("rst_rd_data", rd_data[63:0], 64'd0);
    #2 rst_n = 1'b1;
    step();

    // First op to addr 5, then read next cycle (forwarded from S1)
    set_op(1'b1, 10'd5, 4'b1111, pk(1, 2, 3, 4));
    step();
    chk("busy_s1", {63'b0, busy}, 64'd1);
    idle(); rd_en = 1'b1; rd_addr = 10'd5;
    step();
    chk("a5_valid", {63'b0, rd_valid}, 64'd1);
    chk_lanes("a5", 1, 2, 3, 4);
    chk("a5_sat", {60'b0, sat_flag}, 64'd0);
    idle();
    step();
    chk("a5_valid_drop", {63'b0, rd_valid}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);

    // Back-to-back chain on addr 7
    set_op(1'b1, 10'd7, 4'b1111, pk(10, 10, 10, 10)); step();
    set_op(1'b0, 10'd7, 4'b1111, pk(-3, 5, 0, 1));    step();
    set_op(1'b0, 10'd7, 4'b1111, pk(1, 1, 1, 1));     step();
    idle(); rd_en = 1'b1; rd_addr = 10'd7; step();
    chk_lanes("a7_fwd", 8, 16, 11, 12);
    idle(); step(); step();
    rd_en = 1'b1; rd_addr = 10'd7; step();
    chk_lanes("a7_ram", 8, 16, 11, 12);

    // Read at the same edge as the second op to addr 9
    set_op(1'b1, 10'd9, 4'b1111, pk(2, 2, 2, 2)); rd_en = 1'b0; step();
    set_op(1'b0, 10'd9, 4'b1111, pk(3, 3, 3, 3)); rd_en = 1'b1; rd_addr = 10'd9; step();
    chk_lanes("a9_early", 2, 2, 2, 2);
    acc_valid = 1'b0; step();
    chk_lanes("a9_late", 5, 5, 5, 5);
    idle(); step();

    // Lane mask with acc_first on addr 3
    set_op(1'b1, 10'd3, 4'b1111, pk(1, 1, 1, 1)); step();
    idle(); step();
    set_op(1'b1, 10'd3, 4'b0101, pk(9, 9, 9, 9)); step();
    idle(); step();
    rd_en = 1'b1; rd_addr = 10'd3; step();
    chk_lanes("a3_mask", 9, 1, 9, 1);
    idle(); step();

    // Build 2^39-10 on addr 0 lane 0: 256*(2^31-1) + 246
    set_op(1'b1, 10'd0, 4'b1111, pk(32'h7fffffff, 0, 0, 0)); step();
    for (int k = 0; k < 255; k++) begin
      set_op(1'b0, 10'd0, 4'b1111, pk(32'h7fffffff, 0, 0, 0)); step();
    end
    set_op(1'b0, 10'd0, 4'b1111, pk(246, 0, 0, 0)); step();
    idle(); step();
    rd_en = 1'b1; rd_addr = 10'd0; step();
    chk("sat_pre_l0", ln(0), e40(MAXD - 9));
    chk("sat_pre_flag", {60'b0, sat_flag}, 64'd0);
    idle();
    set_op(1'b0, 10'd0, 4'b0001, pk(32'h7fffffff, 0, 0, 0)); step();
    idle(); step();
    chk("sat_set", {60'b0, sat_flag}, 64'd1);
    rd_en = 1'b1; rd_addr = 10'd0; step();
    chk("sat_clamp_l0", ln(0), e40(MAXD));
    chk("sat_l1_untouched", ln(1), e40(0));
    idle(); step(); step();
    chk("sat_sticky", {60'b0, sat_flag}, 64'd1);
    sat_clr = 1'b1; step();
    chk("sat_clr", {60'b0, sat_flag}, 64'd0);
    idle(); step();

    // Reset while S1 holds an op to addr 4
    set_op(1'b1, 10'd4, 4'b1111, pk(7, 7, 7, 7)); step();
    idle(); step();
    set_op(1'b0, 10'd0, 4'b0001, pk(MAXI, 0, 0, 0)); step();
    set_op(1'b0, 10'd4, 4'b1111, pk(1, 1, 1, 1)); rd_en = 1'b1; rd_addr = 10'd4; step();
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    chk("pre_rst_valid", {63'b0, rd_valid}, 64'd1);
    chk("pre_rst_sat", {60'b0, sat_flag}, 64'd1);
    chk("pre_rst_a4", ln(0), e40(7));
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", {63'b0, busy}, 64'd0);
    chk("async_valid", {63'b0, rd_valid}, 64'd0);
    chk("async_sat", {60'b0, sat_flag}, 64'd0);
    chk("async_rd_data", rd_data[63:0], 64'd0);
    idle();
    step();
    #2 rst_n = 1'b1;
    step();
    rd_en = 1'b1; rd_addr = 10'd4; step();
    chk_lanes("a4_kept", 7, 7, 7, 7);
    idle(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
